cm_vec_ser: RTL and testbench

Vector-to-stream serializer for the output side of the parallel sorting network. It accepts a whole `DATA_CNT`-element vector in one cycle and emits the elements one per cycle, lowest index first, over a valid/ready stream. Each element carries its position and an end-of-vector flag. Two ping-pong vector buffers let the upstream sorter hand over a new vector while the previous one drains, so consecutive vectors stream with no bubble.

---
 rtl/cm_vec_ser.sv | 163 ++++++++++++++++
 tb/tb_cm_vec_ser.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cm_vec_ser.sv
// cm_vec_ser: vector-to-stream serializer for the sorting network output.
// A whole DATA_CNT-element vector is accepted in one cycle into one of two
// ping-pong buffers and then emitted one element per cycle, lowest index
// first, over a valid/ready stream. The second buffer lets the next vector
// be handed over while the current one drains, so vectors stream gap-free.
//
// Optional feature macro: CM_VEC_SER_DEDUP_EN
//   defined   : elements equal to their lower neighbour are skipped
//               (element 0 always emitted); o_idx keeps the original index.
//   undefined : every element is emitted.
//
// Ports:
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_vld/o_rdy  : input vector handshake (o_rdy from registered state only)
//   i_data       : input vector, element 0 in the lowest slice
//   o_vld/i_rdy  : output element handshake
//   o_data       : current element
//   o_idx        : original position of the current element
//   o_last       : final element emitted for its vector
module cm_vec_ser #(
  parameter  int unsigned DATA_CNT   = 4,
  parameter  int unsigned DATA_WIDTH = 8,
  localparam int unsigned IDX_WIDTH  = (DATA_CNT > 1) ? $clog2(DATA_CNT) : 1
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic                                 i_vld,
  output logic                                 o_rdy,
  input  logic [DATA_CNT-1:0][DATA_WIDTH-1:0]  i_data,
  output logic                                 o_vld,
  input  logic                                 i_rdy,
  output logic [DATA_WIDTH-1:0]                o_data,
  output logic [IDX_WIDTH-1:0]                 o_idx,
  output logic                                 o_last
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  localparam logic [IDX_WIDTH-1:0] IDX_MAX = IDX_WIDTH'(DATA_CNT - 1);

  state_t                                     state, state_nxt;
  logic [1:0][DATA_CNT-1:0][DATA_WIDTH-1:0]   mem;
  logic [1:0]                                 full, full_nxt;
  logic                                       wp, rp, rp_nxt;
  logic [IDX_WIDTH-1:0]                       idx, idx_nxt, idx_step;
  logic                                       accept;
  logic                                       last;

  // Reset gating keeps o_rdy low during reset even though the cleared
  // full flags alone would already report the buffers as empty.
  assign o_rdy  = !full[wp] && !i_rst;
  assign accept = i_vld && o_rdy;

`ifdef CM_VEC_SER_DEDUP_EN
  logic [1:0][DATA_CNT-1:0] keep;
  logic [DATA_CNT-1:0]      keep_in;

  always_comb begin
    keep_in    = '0;
    keep_in[0] = 1'b1;
    for (int unsigned n = 1; n < DATA_CNT; n++) begin
      keep_in[n] = (i_data[n] != i_data[n-1]);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      keep <= '0;
    end else if (accept) begin
      keep[wp] <= keep_in;
    end
  end

  // Scan from the top down so the last hit is the lowest kept index above
  // idx; no hit means idx is the final element of this vector.
  always_comb begin
    idx_step = idx;
    last     = 1'b1;
    for (int unsigned k = 0; k < DATA_CNT; k++) begin
      if (((DATA_CNT - 1 - k) > 32'(idx)) && keep[rp][DATA_CNT-1-k]) begin
        idx_step = IDX_WIDTH'(DATA_CNT - 1 - k);
        last     = 1'b0;
      end
    end
  end
`else
  always_comb begin
    last     = (idx == IDX_MAX);
    idx_step = idx + IDX_WIDTH'(1);
  end
`endif

  always_ff @(posedge i_clk) begin
    if (accept) begin
      mem[wp] <= i_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= S_IDLE;
      full  <= '0;
      wp    <= 1'b0;
      rp    <= 1'b0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      full  <= full_nxt;
      wp    <= wp ^ accept;
      rp    <= rp_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    full_nxt  = full;
    rp_nxt    = rp;
    idx_nxt   = idx;
    o_vld     = 1'b0;
    o_data    = '0;
    o_idx     = '0;
    o_last    = 1'b0;

    if (accept) begin
      full_nxt[wp] = 1'b1;
    end

    case (state)
      S_IDLE: begin
        // Entering on the accept itself gives one-cycle latency.
        if (full[rp] || (accept && (wp == rp))) begin
          state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        o_vld  = 1'b1;
        o_data = mem[rp][idx];
        o_idx  = idx;
        o_last = last;
        if (i_rdy) begin
          if (!last) begin
            idx_nxt = idx_step;
          end else begin
            full_nxt[rp] = 1'b0;
            rp_nxt       = !rp;
            idx_nxt      = '0;
            // A vector landing in the other buffer this same cycle keeps
            // the stream going without an idle cycle.
            if (!(full[!rp] || (accept && (wp != rp)))) begin
              state_nxt = S_IDLE;
            end
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cm_vec_ser.sv
// Self-checking bench for cm_vec_ser: a reference model expands each accepted
// vector into its expected element stream (queue); a monitor pops and
// compares on every output transfer. Honors CM_VEC_SER_DEDUP_EN.
module tb_cm_vec_ser;
  localparam int unsigned CNT = 4;
  localparam int unsigned W   = 8;
  localparam int unsigned IW  = 2;

  typedef logic [CNT-1:0][W-1:0] vec_t;
  typedef struct packed {
    logic [W-1:0]  d;
    logic [IW-1:0] idx;
    logic          last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_vld;
  logic          in_rdy;
  vec_t          in_data;
  logic          out_vld;
  logic          out_rdy;
  logic [W-1:0]  out_data;
  logic [IW-1:0] out_idx;
  logic          out_last;

  int   checks = 0;
  int   errors = 0;
  int   n_pop  = 0;
  int   rdy_mode = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  cm_vec_ser #(.DATA_CNT(CNT), .DATA_WIDTH(W)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_vld  (in_vld),
    .o_rdy  (in_rdy),
    .i_data (in_data),
    .o_vld  (out_vld),
    .i_rdy  (out_rdy),
    .o_data (out_data),
    .o_idx  (out_idx),
    .o_last (out_last)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int a, input int b, input int c, input int d);
    vec_t v;
    v[0] = W'(a);
    v[1] = W'(b);
    v[2] = W'(c);
    v[3] = W'(d);
    return v;
  endfunction

  // Reference: list the positions that survive, mark the highest one last.
  task automatic expect_vec(input vec_t v);
    logic keep [CNT];
    int   last_k = 0;
    exp_t e;
    for (int n = 0; n < CNT; n++) begin
      keep[n] = 1'b1;
`ifdef CM_VEC_SER_DEDUP_EN
      if (n > 0) keep[n] = (v[n] != v[n-1]);
`endif
      if (keep[n]) last_k = n;
    end
    for (int n = 0; n < CNT; n++) begin
      if (keep[n]) begin
        e.d    = v[n];
        e.idx  = IW'(n);
        e.last = (n == last_k);
        sb.push_back(e);
      end
    end
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send_vec(input vec_t v);
    int g = 0;
    in_vld  = 1'b1;
    in_data = v;
    forever begin
      #2;
      if (in_rdy) begin
        expect_vec(v);
        break;
      end
      g++;
      if (g > 200) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: got o_rdy=0 for %0d cycles expected 1", g);
        in_vld = 1'b0;
        return;
      end
      @(negedge clk);
    end
    @(negedge clk);
    in_vld = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int g = 0;
    while (sb.size() != 0 && g < 500) begin
      @(negedge clk);
      g++;
    end
    repeat (2) @(negedge clk);
    #2;
    chk(name, sb.size(), 0);
    chk({name, "_idle"}, out_vld, 0);
  endtask

  // Downstream ready: 0 = always, 1 = pattern 1,0,0,1,0,1, 2 = random.
  initial begin
    logic [5:0] pat;
    int pos;
    pat = 6'b101001;
    pos = 0;
    out_rdy = 1'b1;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       out_rdy = 1'b1;
        1: begin out_rdy = pat[pos % 6]; pos++; end
        default: out_rdy = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: element compare, stall hold, output gating.
  initial begin
    exp_t          e;
    logic          stall_prev;
    logic [W-1:0]  p_d;
    logic [IW-1:0] p_i;
    logic          p_l;
    stall_prev = 1'b0;
    p_d = '0;
    p_i = '0;
    p_l = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        stall_prev = 1'b0;
        continue;
      end
      if (stall_prev) begin
        checks++;
        if (!(out_vld && out_data == p_d && out_idx == p_i && out_last == p_l)) begin
          errors++;
          $display("FAIL stall_hold: got vld=%0d data=%0d idx=%0d last=%0d expected vld=1 data=%0d idx=%0d last=%0d",
                   out_vld, out_data, out_idx, out_last, p_d, p_i, p_l);
        end
      end
      if (out_vld) begin
        if (out_rdy) begin
          checks++;
          n_pop++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected: got data=%0d idx=%0d last=%0d expected no output",
                     out_data, out_idx, out_last);
          end else begin
            e = sb.pop_front();
            if (out_data != e.d || out_idx != e.idx || out_last != e.last) begin
              errors++;
              $display("FAIL elem: got data=%0d idx=%0d last=%0d expected data=%0d idx=%0d last=%0d",
                       out_data, out_idx, out_last, e.d, e.idx, e.last);
            end
          end
        end
        stall_prev = !out_rdy;
        p_d = out_data;
        p_i = out_idx;
        p_l = out_last;
      end else begin
        stall_prev = 1'b0;
        checks++;
        if (out_data != '0 || out_idx != '0 || out_last != 1'b0) begin
          errors++;
          $display("FAIL gating: got data=%0d idx=%0d last=%0d expected 0 0 0",
                   out_data, out_idx, out_last);
        end
      end
    end
  end

  initial begin
    int base;
    int g;
    rst     = 1'b1;
    in_vld  = 1'b0;
    in_data = '0;

    // Reset state
    repeat (2) @(negedge clk);
    #2;
    chk("rst_rdy", in_rdy, 0);
    chk("rst_vld", out_vld, 0);
    chk("rst_data", out_data, 0);
    chk("rst_idx", out_idx, 0);
    chk("rst_last", out_last, 0);
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("rel_rdy", in_rdy, 1);
    chk("rel_vld", out_vld, 0);

    // Single vector and first-element latency
    @(negedge clk);
    send_vec(mk(4, 7, 9, 12));
    #2;
    chk("lat_vld", out_vld, 1);
    chk("lat_data", out_data, 4);
    chk("lat_idx", out_idx, 0);
    wait_drain("single");

    // Back-to-back: no bubble, o_rdy low while both buffers full
    @(negedge clk);
    fork
      begin
        send_vec(mk(1, 2, 3, 4));
        send_vec(mk(5, 6, 7, 8));
        send_vec(mk(9, 10, 11, 12));
      end
      begin
        logic [12:1] rdys;
        int run;
        g   = 0;
        run = 0;
        rdys = '0;
        #2;
        while (!out_vld && g < 50) begin
          @(negedge clk);
          #2;
          g++;
        end
        for (int k = 1; k <= 12; k++) begin
          if (k > 1) begin
            @(negedge clk);
            #2;
          end
          if (out_vld && run == k - 1) run++;
          rdys[k] = in_rdy;
        end
`ifdef CM_VEC_SER_DEDUP_EN
        chk("b2b_first_rdy", rdys[1], 1);
`else
        chk("no_bubble", run, 12);
        chk("b2b_first_rdy", rdys[1], 1);
        chk("rdy_both_full", rdys[4:2], 0);
        chk("rdy_reopen", rdys[5], 1);
`endif
      end
    join
    wait_drain("b2b");

    // Backpressure pattern
    rdy_mode = 1;
    @(negedge clk);
    send_vec(mk(4, 7, 9, 12));
    wait_drain("bp");
    rdy_mode = 0;

    // Duplicates
    @(negedge clk);
    send_vec(mk(3, 3, 5, 5));
    wait_drain("dup");

    // Reset mid-vector, then restart
    base = n_pop;
    @(negedge clk);
    send_vec(mk(4, 7, 9, 12));
    g = 0;
    while (n_pop < base + 2 && g < 50) begin
      @(negedge clk);
      #3;
      g++;
    end
    chk("mid_pop", n_pop - base, 2);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("mid_rst_vld", out_vld, 0);
    chk("mid_rst_rdy", in_rdy, 0);
    chk("mid_rst_data", out_data, 0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #2;
    chk("mid_rel_rdy", in_rdy, 1);
    chk("mid_rel_vld", out_vld, 0);
    @(negedge clk);
    send_vec(mk(9, 9, 9, 9));
    #2;
    chk("restart_idx", out_idx, 0);
    chk("restart_data", out_data, 9);
    wait_drain("restart");

    // Randomized traffic with random backpressure and gaps
    rdy_mode = 2;
    @(negedge clk);
    for (int t = 0; t < 40; t++) begin
      vec_t v;
      for (int n = 0; n < CNT; n++) begin
        if (t % 2 == 0) v[n] = W'($urandom_range(0, 3));
        else            v[n] = W'($urandom_range(0, 255));
      end
      send_vec(v);
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
    end
    wait_drain("random");
    rdy_mode = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
